// File: rtl/stack_ctrl_if.sv
// Stack control bus: request/response signals between the requester,
// the SP register and the byte-wide data memory.
//   slave  : sequencer side (stack_ctrl)
//   master : environment side (requester, SP register, memory)
// Requests  : PUSH, POP, DATA_IN
// SP reg    : SP_Q (in), SP_D / SP_ENA (out)
// Memory    : MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE (out), MEM_RDATA (in)
// Status    : DATA_OUT, BUSY, DONE, OVF, UNF
interface stack_ctrl_if;
    logic        PUSH;
    logic        POP;
    logic [15:0] DATA_IN;
    logic [15:0] SP_Q;
    logic [7:0]  MEM_RDATA;
    logic [15:0] SP_D;
    logic        SP_ENA;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_WE;
    logic        MEM_RE;
    logic [15:0] DATA_OUT;
    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic        UNF;

    modport slave (
        input  PUSH, POP, DATA_IN, SP_Q, MEM_RDATA,
        output SP_D, SP_ENA, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE,
        output DATA_OUT, BUSY, DONE, OVF, UNF
    );

    modport master (
        output PUSH, POP, DATA_IN, SP_Q, MEM_RDATA,
        input  SP_D, SP_ENA, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE,
        input  DATA_OUT, BUSY, DONE, OVF, UNF
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack control sequencer. Splits 16-bit PUSH/POP requests into two byte
// transfers on an 8-bit memory port and drives the load inputs of the
// downward-growing stack pointer register (SP == 0 means empty, SP points
// at the low byte of the top word).
// Ports:
//   CLK  - clock, all state updates on the rising edge
//   RST  - synchronous active-high reset
//   bus  - stack_ctrl_if.slave (requests, SP register load, memory port, status)
//
// state  | meaning
// IDLE   | waiting for PUSH/POP; rejected requests pulse OVF/UNF here
// PUSH_H | write high byte to sp_base-1
// PUSH_L | write low byte to sp_base-2, load SP with sp_base-2
// POP_L  | read low byte from sp_base
// POP_H  | read high byte from sp_base+1, load SP with sp_base+2
// FIN    | DONE pulse, return to IDLE
module stack_ctrl #(
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        CLK,
    input  logic        RST,
    stack_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH_H = 3'd1,
        PUSH_L = 3'd2,
        POP_L  = 3'd3,
        POP_H  = 3'd4,
        FIN    = 3'd5
    } state_t;

    // A push needs two free bytes at or above STACK_LIMIT.
    localparam logic [15:0] LIMIT_P2 = STACK_LIMIT + 16'd2;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] sp_base_q, sp_base_d;
    logic [15:0] data_out_q, data_out_d;
    logic [15:0] sp_d_q, sp_d_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        sp_ena;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            sp_base_q  <= '0;
            data_out_q <= '0;
            sp_d_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            sp_base_q  <= sp_base_d;
            data_out_q <= data_out_d;
            sp_d_q     <= sp_d_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        sp_base_d  = sp_base_q;
        data_out_d = data_out_q;
        sp_d_d     = sp_d_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        sp_ena     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.PUSH) begin
                    // SP == 0 is the empty stack, which always has room.
                    if (bus.SP_Q != 16'h0000 && bus.SP_Q < LIMIT_P2) begin
                        ovf_d = 1'b1;
                    end else begin
                        hold_d    = bus.DATA_IN;
                        sp_base_d = bus.SP_Q;
                        state_d   = PUSH_H;
                    end
                end else if (bus.POP) begin
                    if (bus.SP_Q == 16'h0000) begin
                        unf_d = 1'b1;
                    end else begin
                        sp_base_d = bus.SP_Q;
                        state_d   = POP_L;
                    end
                end
            end
            PUSH_H: begin
                mem_addr  = sp_base_q - 16'd1;
                mem_wdata = hold_q[15:8];
                mem_we    = 1'b1;
                state_d   = PUSH_L;
            end
            PUSH_L: begin
                mem_addr  = sp_base_q - 16'd2;
                mem_wdata = hold_q[7:0];
                mem_we    = 1'b1;
                sp_d_d    = sp_base_q - 16'd2;
                sp_ena    = 1'b1;
                state_d   = FIN;
            end
            POP_L: begin
                mem_addr         = sp_base_q;
                mem_re           = 1'b1;
                data_out_d[7:0]  = bus.MEM_RDATA;
                state_d          = POP_H;
            end
            POP_H: begin
                mem_addr         = sp_base_q + 16'd1;
                mem_re           = 1'b1;
                data_out_d[15:8] = bus.MEM_RDATA;
                sp_d_d           = sp_base_q + 16'd2;
                sp_ena           = 1'b1;
                state_d          = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SP_D shows the new pointer during the load cycle and holds it afterwards.
    assign bus.SP_D      = sp_d_d;
    assign bus.SP_ENA    = sp_ena;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;
    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_RE    = mem_re;
    assign bus.DATA_OUT  = data_out_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = (state_q == FIN);
    assign bus.OVF       = ovf_q;
    assign bus.UNF       = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

    localparam logic [15:0] LIMIT = 16'hFF00;
    localparam int          CAP   = (65536 - int'(LIMIT)) / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_ctrl_if bus ();

    stack_ctrl #(.STACK_LIMIT(LIMIT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Environment: byte memory and SP register (loads on falling edge).
    logic [7:0]  mem [0:65535];
    logic [15:0] sp_reg;

    assign bus.MEM_RDATA = mem[bus.MEM_ADDR];
    assign bus.SP_Q      = sp_reg;

    always @(posedge clk) if (bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;

    always @(negedge clk) begin
        if (rst)             sp_reg <= 16'h0000;
        else if (bus.SP_ENA) sp_reg <= bus.SP_D;
    end

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model[$];
    logic [15:0] m_dout  = 16'h0000;
    logic [15:0] spd_exp = 16'h0000;

    typedef struct {
        bit          push;
        bit          pop;
        logic [15:0] din;
        bit          e_ovf;
        bit          e_unf;
        logic [15:0] e_dout;
        logic [15:0] e_sp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, bus.BUSY},   0);
        chk({tag, "_done"},  {31'd0, bus.DONE},   0);
        chk({tag, "_ovf"},   {31'd0, bus.OVF},    0);
        chk({tag, "_unf"},   {31'd0, bus.UNF},    0);
        chk({tag, "_ena"},   {31'd0, bus.SP_ENA}, 0);
        chk({tag, "_we"},    {31'd0, bus.MEM_WE}, 0);
        chk({tag, "_re"},    {31'd0, bus.MEM_RE}, 0);
        chk({tag, "_addr"},  {16'd0, bus.MEM_ADDR}, 0);
        chk({tag, "_wdata"}, {24'd0, bus.MEM_WDATA}, 0);
        chk({tag, "_spd"},   {16'd0, bus.SP_D}, 0);
        chk({tag, "_dout"},  {16'd0, bus.DATA_OUT}, 0);
    endtask

    // Stack depth determines SP: each word takes two bytes below 0x10000.
    function automatic logic [15:0] model_sp();
        logic [31:0] t;
        t = 32'h10000 - 32'(2 * model.size());
        return t[15:0];
    endfunction

    task automatic model_op(input bit push, input bit pop, input logic [15:0] din,
                            output bit e_ovf, output bit e_unf);
        e_ovf = push && (model.size() >= CAP);
        e_unf = !push && pop && (model.size() == 0);
        if (push && !e_ovf)              model.push_back(din);
        else if (!push && pop && !e_unf) m_dout = model.pop_back();
    endtask

    // Issue one request from IDLE and watch it to completion. poke (1..3)
    // raises PUSH and POP for one edge while the operation is in flight.
    task automatic run_op(input string tag, input bit push, input bit pop,
                          input logic [15:0] din, input int poke,
                          input bit e_ovf, input bit e_unf,
                          input logic [15:0] e_dout, input logic [15:0] e_sp);
        bit          is_push = push && !e_ovf;
        bit          is_pop  = !push && pop && !e_unf;
        bit          acc     = is_push || is_pop;
        int          we_n = 0, re_n = 0, ena_n = 0, ovf_n = 0, unf_n = 0, done_n = 0, done_k = 0;
        logic [15:0] wa [2];
        logic [7:0]  wd [2];
        logic [15:0] ra [2];
        logic [15:0] spd_seen = 16'h0000;
        logic [15:0] a_hi, a_lo;
        bit          last;

        bus.PUSH = push; bus.POP = pop; bus.DATA_IN = din;
        @(posedge clk); #1;
        bus.PUSH = 1'b0; bus.POP = 1'b0; bus.DATA_IN = 16'($urandom);

        for (int k = 1; k <= 6; k++) begin
            if (k == 1) chk({tag, "_busy_accept"}, {31'd0, bus.BUSY}, {31'd0, acc});
            chk({tag, "_we_re_excl"}, {31'd0, bus.MEM_WE & bus.MEM_RE}, 0);
            if (!bus.MEM_WE && !bus.MEM_RE)
                chk({tag, "_idle_bus"}, {8'd0, bus.MEM_ADDR, bus.MEM_WDATA}, 0);
            if (bus.MEM_WE) begin
                if (we_n < 2) begin wa[we_n] = bus.MEM_ADDR; wd[we_n] = bus.MEM_WDATA; end
                we_n++;
            end
            if (bus.MEM_RE) begin
                if (re_n < 2) ra[re_n] = bus.MEM_ADDR;
                re_n++;
            end
            if (bus.SP_ENA) begin ena_n++; spd_seen = bus.SP_D; end
            if (bus.OVF) ovf_n++;
            if (bus.UNF) unf_n++;
            if (bus.DONE) begin done_n++; if (done_k == 0) done_k = k; end
            if (acc && k == poke) begin bus.PUSH = 1'b1; bus.POP = 1'b1; end
            last = bus.DONE || (!acc && k == 2);
            @(posedge clk); #1;
            bus.PUSH = 1'b0; bus.POP = 1'b0;
            if (last) break;
        end

        if (acc) spd_exp = e_sp;
        chk({tag, "_busy_end"}, {31'd0, bus.BUSY}, 0);
        chk({tag, "_done_cycle"}, done_k, acc ? 3 : 0);
        chk({tag, "_done_cnt"}, done_n, acc ? 1 : 0);
        chk({tag, "_ovf"}, ovf_n, {31'd0, e_ovf});
        chk({tag, "_unf"}, unf_n, {31'd0, e_unf});
        chk({tag, "_we_cnt"}, we_n, is_push ? 2 : 0);
        chk({tag, "_re_cnt"}, re_n, is_pop ? 2 : 0);
        chk({tag, "_ena_cnt"}, ena_n, acc ? 1 : 0);
        chk({tag, "_dout"}, {16'd0, bus.DATA_OUT}, {16'd0, e_dout});
        chk({tag, "_sp"}, {16'd0, sp_reg}, {16'd0, e_sp});
        chk({tag, "_spd_hold"}, {16'd0, bus.SP_D}, {16'd0, spd_exp});
        if (is_push && we_n == 2) begin
            a_hi = e_sp + 16'd1;
            chk({tag, "_w0_addr"}, {16'd0, wa[0]}, {16'd0, a_hi});
            chk({tag, "_w0_data"}, {24'd0, wd[0]}, {24'd0, din[15:8]});
            chk({tag, "_w1_addr"}, {16'd0, wa[1]}, {16'd0, e_sp});
            chk({tag, "_w1_data"}, {24'd0, wd[1]}, {24'd0, din[7:0]});
            chk({tag, "_spd"}, {16'd0, spd_seen}, {16'd0, e_sp});
        end
        if (is_pop && re_n == 2) begin
            a_lo = e_sp - 16'd2;
            a_hi = e_sp - 16'd1;
            chk({tag, "_r0_addr"}, {16'd0, ra[0]}, {16'd0, a_lo});
            chk({tag, "_r1_addr"}, {16'd0, ra[1]}, {16'd0, a_hi});
            chk({tag, "_spd"}, {16'd0, spd_seen}, {16'd0, e_sp});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          e_ovf, e_unf, push, pop;
        logic [15:0] din;
        int          r, poke, we_n, ena_n;

        tbl[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'hA55A, 1'b0, 1'b0, 16'h0000, 16'hFFFE};
        tbl[2] = '{1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'hFFFC};
        tbl[3] = '{1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 16'hFFFA};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0F0F, 16'hFFFC};
        tbl[5] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'hFFFE};
        tbl[6] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hA55A, 16'h0000};
        tbl[7] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'hA55A, 16'h0000};

        bus.PUSH = 1'b0; bus.POP = 1'b0; bus.DATA_IN = 16'h0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        chk("reset_sp", {16'd0, sp_reg}, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), tbl[i].push, tbl[i].pop, tbl[i].din, 0,
                   tbl[i].e_ovf, tbl[i].e_unf, tbl[i].e_dout, tbl[i].e_sp);

        // Requests raised mid-operation must be dropped.
        run_op("push_poke", 1'b1, 1'b0, 16'hC3C3, 2, 1'b0, 1'b0, 16'hA55A, 16'hFFFE);
        run_op("pop_poke",  1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0, 16'hC3C3, 16'h0000);

        // Reset during PUSH_H aborts without the low-byte write or SP load.
        bus.PUSH = 1'b1; bus.DATA_IN = 16'hBEEF;
        @(posedge clk); #1;
        bus.PUSH = 1'b0;
        chk("rstmid_we_h", {31'd0, bus.MEM_WE}, 1);
        chk("rstmid_addr_h", {16'd0, bus.MEM_ADDR}, 32'hFFFF);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_idle_zero("rstmid");
        rst = 1'b0;
        we_n = 0; ena_n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            we_n  += int'(bus.MEM_WE);
            ena_n += int'(bus.SP_ENA);
        end
        chk("rstmid_no_we", we_n, 0);
        chk("rstmid_no_ena", ena_n, 0);
        chk("rstmid_sp", {16'd0, sp_reg}, 0);
        model.delete();
        m_dout  = 16'h0000;
        spd_exp = 16'h0000;

        // Fill to capacity, then a rejected push and a pop of the top word.
        for (int i = 0; i < CAP; i++) begin
            din = 16'h1000 + 16'(i);
            model_op(1'b1, 1'b0, din, e_ovf, e_unf);
            run_op($sformatf("fill%0d", i), 1'b1, 1'b0, din, 0, e_ovf, e_unf, m_dout, model_sp());
        end
        chk("full_sp", {16'd0, sp_reg}, {16'd0, LIMIT});
        model_op(1'b1, 1'b0, 16'h1234, e_ovf, e_unf);
        chk("full_model_ovf", {31'd0, e_ovf}, 1);
        run_op("full_push", 1'b1, 1'b0, 16'h1234, 0, e_ovf, e_unf, m_dout, model_sp());
        model_op(1'b0, 1'b1, 16'h0000, e_ovf, e_unf);
        run_op("full_pop", 1'b0, 1'b1, 16'h0000, 0, e_ovf, e_unf, m_dout, model_sp());
        chk("full_pop_word", {16'd0, bus.DATA_OUT}, 32'h107F);

        // Random walk starting near full so overflow and refill both occur.
        for (int n = 0; n < 300; n++) begin
            r    = int'($urandom_range(0, 9));
            push = (r <= 3) || (r == 8);
            pop  = (r >= 4) && (r <= 8);
            din  = 16'($urandom);
            model_op(push, pop, din, e_ovf, e_unf);
            poke = ((push && !e_ovf) || (!push && pop && !e_unf)) ? int'($urandom_range(0, 3)) : 0;
            run_op($sformatf("rnd%0d", n), push, pop, din, poke, e_ovf, e_unf, m_dout, model_sp());
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
